// File: rtl/hamming_scrubber.sv
// SECDED memory scrubber: reads every word once per pass, rewrites
// single-bit-corrected words and counts uncorrectable ones.
module hamming_scrubber #(
    parameter int p_dataSize          = 8,
    parameter int p_depth             = 16,
    parameter int p_zeroWordDetection = 0,
    localparam int R  = $clog2(p_dataSize + 1 + $clog2(p_dataSize + 1)),
    localparam int CW = p_dataSize + R + 1,
    localparam int AW = $clog2(p_depth)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          memReady,
    input  logic [CW-1:0] memRdata,
    output logic [AW-1:0] memAddr,
    output logic          memRE,
    output logic          memWE,
    output logic [CW-1:0] memWdata,
    output logic          busy,
    output logic          done,
    output logic [15:0]   corrCount,
    output logic [15:0]   uncorrCount,
    output logic          uncorrFlag,
    output logic [AW-1:0] firstUncorrAddr
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [AW-1:0] LAST = AW'(p_depth - 1);

    logic [2:0]    r_state;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_first;
    logic [CW-1:0] r_rdata;
    logic [CW-1:0] r_wdata;
    logic [15:0]   r_corr;
    logic [15:0]   r_uncorr;
    logic          r_flag;
    logic          r_done;

    logic [R-1:0]  w_syn;
    logic          w_par;
    logic          w_zero;
    logic          w_corr;
    logic          w_uncorr;
    logic [CW-1:0] w_fixed;

    // Syndrome/parity decode of the captured word and its corrected form
    always_comb begin
        w_syn = '0;
        w_par = 1'b0;
        for (int i = 0; i < CW; i++) begin
            w_par = w_par ^ r_rdata[i];
            if (r_rdata[i]) begin
                w_syn = w_syn ^ R'(i);
            end
        end
        w_zero   = (p_zeroWordDetection != 0) && (r_rdata == '0);
        w_corr   = w_par && (int'(w_syn) < CW) && !w_zero;
        w_uncorr = w_zero || (!w_corr && (w_par || (w_syn != '0)));
        w_fixed  = r_rdata;
        for (int i = 0; i < CW; i++) begin
            if (R'(i) == w_syn) begin
                w_fixed[i] = ~r_rdata[i];
            end
        end
    end

    // Pass sequencing, error bookkeeping and writeback data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_first  <= '0;
            r_rdata  <= '0;
            r_wdata  <= '0;
            r_corr   <= '0;
            r_uncorr <= '0;
            r_flag   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_READ;
                        r_addr   <= '0;
                        r_first  <= '0;
                        r_corr   <= '0;
                        r_uncorr <= '0;
                        r_flag   <= 1'b0;
                    end
                end
                S_READ: begin
                    if (memReady) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_rdata <= memRdata;
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (w_corr) begin
                        if (r_corr != 16'hFFFF) begin
                            r_corr <= r_corr + 16'd1;
                        end
                        r_wdata <= w_fixed;
                        r_state <= S_WB;
                    end else begin
                        if (w_uncorr) begin
                            if (r_uncorr != 16'hFFFF) begin
                                r_uncorr <= r_uncorr + 16'd1;
                            end
                            r_flag <= 1'b1;
                            if (!r_flag) begin
                                r_first <= r_addr;
                            end
                        end
                        if (r_addr == LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= S_READ;
                        end
                    end
                end
                S_WB: begin
                    if (memReady) begin
                        if (r_addr == LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign memAddr         = r_addr;
    assign memRE           = (r_state == S_READ);
    assign memWE           = (r_state == S_WB);
    assign memWdata        = r_wdata;
    assign busy            = (r_state != S_IDLE);
    assign done            = r_done;
    assign corrCount       = r_corr;
    assign uncorrCount     = r_uncorr;
    assign uncorrFlag      = r_flag;
    assign firstUncorrAddr = r_first;

endmodule

// File: doc/hamming_scrubber.md
HAMMING_SCRUBBER -- requirements
Module: hamming_scrubber

Interface
REQ-001 SHALL have parameter p_dataSize, default 8, data bits per stored word.
REQ-002 SHALL have parameter p_depth, default 16, number of words scrubbed per pass.
REQ-003 SHALL have parameter p_zeroWordDetection, default 0; when 1, an all-zero codeword is uncorrectable.
REQ-004 SHALL define R as the smallest r with 2^r >= p_dataSize+r+1, codeword width CW = p_dataSize+R+1, and address width AW = $clog2(p_depth).
REQ-005 SHALL have clk  in  1  sole clock; all state changes on rising edge.
REQ-006 SHALL have rst  in  1  reset; synchronous and active-high.
REQ-007 SHALL have start  in  1  begin one scrub pass; sampled only in IDLE.
REQ-008 SHALL have memReady  in  1  memory accepts the current read/write request this cycle.
REQ-009 SHALL have memRdata  in  CW  read codeword, valid the cycle after an accepted read.
REQ-010 SHALL have memAddr  out  AW  address of the current word.
REQ-011 SHALL have memRE / memWE  out  1 each  read / write request, held until accepted.
REQ-012 SHALL have memWdata  out  CW  corrected codeword.
REQ-013 SHALL have busy  out  1, done  out  1 (one-cycle pulse at pass end).
REQ-014 SHALL have corrCount / uncorrCount  out  16 each  per-pass saturating error counters.
REQ-015 SHALL have uncorrFlag  out  1, sticky; firstUncorrAddr  out  AW  address of the first uncorrectable word in the pass.

Function
REQ-016 Codeword layout SHALL be:
- bit 0: overall parity over all CW bits.
- bits 1..CW-1: Hamming positions; parity bits at power-of-two indices.
- data bits fill the remaining indices in ascending order, LSB first.
REQ-017 Decode SHALL compute syndrome s (XOR of indices 1..CW-1 of set bits) and p (XOR of all CW bits):
- s=0, p=0: clean.
- p=1, s=0: bit 0 error, correctable.
- p=1, 1<=s<=CW-1: flip bit s, correctable.
- p=1, s>CW-1: uncorrectable.
- s!=0, p=0: uncorrectable.
REQ-018 When p_zeroWordDetection=1, an all-zero memRdata SHALL be classed as uncorrectable, overriding REQ-017.
REQ-019 FSM states SHALL be IDLE, READ, WAIT, CHECK, WRITEBACK, DONE.
REQ-020 IDLE with start=1 SHALL go to READ and SHALL, at that edge, set memAddr=0, clear both counters, uncorrFlag and firstUncorrAddr.
REQ-021 READ SHALL assert memRE and stay in READ until memReady=1, then go to WAIT.
REQ-022 WAIT SHALL register memRdata and go to CHECK; memRE and memWE SHALL be 0 in WAIT.
REQ-023 CHECK on a correctable word SHALL:
- increment corrCount;
- load memWdata with the corrected codeword;
- go to WRITEBACK.
REQ-024 CHECK on a clean word SHALL not write back.
REQ-025 CHECK on an uncorrectable word SHALL:
- increment uncorrCount;
- not write back;
- set uncorrFlag;
- capture memAddr into firstUncorrAddr, only if uncorrFlag was 0.
REQ-026 WRITEBACK SHALL assert memWE with memAddr unchanged and stay until memReady=1.
REQ-027 After CHECK (no writeback) or an accepted WRITEBACK, the FSM SHALL:
- at memAddr=p_depth-1: go to DONE;
- otherwise: increment memAddr and go to READ.
REQ-028 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-029 busy SHALL be 1 in every state except IDLE; start outside IDLE SHALL be ignored.
REQ-030 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-031 Cycle budget with memReady=1 throughout: clean word 3 cycles, corrected word 4 cycles.
REQ-032 With memReady=1 throughout, done SHALL be high in the cycle 3*p_depth+1 clock edges after the start-sampling edge, plus one per corrected word.
REQ-033 Counters, uncorrFlag and firstUncorrAddr SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-034 rst=1 at an edge SHALL, at that edge and regardless of state (including mid-pass), force:
- state to IDLE;
- memAddr=0, memWdata=0;
- memRE=memWE=busy=done=0;
- counters=0, uncorrFlag=0, firstUncorrAddr=0.
REQ-035 rst SHALL take priority over start; no memory write SHALL be issued in the cycle after rst.

Verification
REQ-036 Defaults, all 16 words clean, memReady=1, start pulse -> 16 reads, no memWE, done after 49 edges, corrCount=uncorrCount=0.
REQ-037 Word 5 with data bit at position 3 flipped -> one memWE at addr 5 with the original codeword, corrCount=1, done one cycle later (50 edges).
REQ-038 Word 2 with bit 0 flipped; word 9 with positions 1 and 6 flipped -> writeback at addr 2 only, corrCount=1, uncorrCount=1, uncorrFlag=1, firstUncorrAddr=9.
REQ-039 memReady held 0 for 4 cycles during the READ of word 3 and the WRITEBACK of word 7 -> memRE/memWE held with a stable address, no skipped or duplicated words, done delayed 8 cycles.
REQ-040 p_zeroWordDetection=1, word 0 all-zero -> uncorrectable, firstUncorrAddr=0; rst asserted at word 10 -> all outputs zero next cycle, and the next start restarts from addr 0.
